// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types, widths and op codes for the ALU command sequencer
`timescale 1ns/1ps
package alu_seq_pkg;

    localparam int DATA_W    = 4;
    localparam int OVF_CNT_W = 8;
    localparam int OP_W      = 2;
    localparam int PAYLOAD_W = OP_W + 2 * DATA_W;
    localparam int SETTLE_W  = 4;

    localparam logic [OP_W-1:0] OP0 = 2'd0;
    localparam logic [OP_W-1:0] OP1 = 2'd1;
    localparam logic [OP_W-1:0] OP2 = 2'd2;
    localparam logic [OP_W-1:0] OP3 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } seq_state_t;

    function automatic logic [PAYLOAD_W-1:0] pack_cmd(
        input logic [OP_W-1:0]   op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        return {op, a, b};
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - in-order command queue with registered head, no fall-through
`timescale 1ns/1ps
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign push_ready = (count < DEPTH_C);
    assign empty      = (count == '0);
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop && !empty;
    assign pop_data   = mem[rd_ptr];

    // Storage needs no reset: the count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - queues ALU commands, waits for settle, captures and holds results
`timescale 1ns/1ps
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int DEPTH         = 4
) (
`ifdef USE_POWER_PINS
    inout  wire                  vccd1,
    inout  wire                  vssd1,
`endif
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [DATA_W-1:0]    cmd_a,
    input  logic [DATA_W-1:0]    cmd_b,
    input  logic [OP_W-1:0]      cmd_op,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic                 alu_ctrl0,
    output logic                 alu_ctrl1,
    input  logic [DATA_W-1:0]    alu_c,
    input  logic                 alu_ovf,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [DATA_W-1:0]    res_c,
    output logic                 res_ovf,
    output logic [OVF_CNT_W-1:0] ovf_count,
    output logic                 busy
);

    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES - 1);

    seq_state_t           state;
    seq_state_t           state_nxt;
    logic [SETTLE_W-1:0]  settle_cnt;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 capture;
    logic [PAYLOAD_W-1:0] head;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (PAYLOAD_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (cmd_valid),
        .push_ready (cmd_ready),
        .push_data  (pack_cmd(cmd_op, cmd_a, cmd_b)),
        .pop        (fifo_pop),
        .pop_data   (head),
        .empty      (fifo_empty)
    );

    assign busy = (state != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand registers change only on a pop so the ALU inputs stay quiet while settling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl0  <= 1'b0;
            alu_ctrl1  <= 1'b0;
            settle_cnt <= '0;
        end else if (fifo_pop) begin
            alu_ctrl1  <= head[PAYLOAD_W-1];
            alu_ctrl0  <= head[PAYLOAD_W-2];
            alu_a      <= head[2*DATA_W-1:DATA_W];
            alu_b      <= head[DATA_W-1:0];
            settle_cnt <= SETTLE_INIT;
        end else if (state == ST_SETTLE && settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_c     <= '0;
            res_ovf   <= 1'b0;
            res_valid <= 1'b0;
            ovf_count <= '0;
        end else if (capture) begin
            res_c     <= alu_c;
            res_ovf   <= alu_ovf;
            res_valid <= 1'b1;
            if (alu_ovf && ovf_count != '1) begin
                ovf_count <= ovf_count + 1'b1;
            end
        end else if (state == ST_HOLD && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed self-checking bench for alu_cmd_sequencer
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_a = '0;
    logic [3:0] cmd_b = '0;
    logic [1:0] cmd_op = '0;
    logic [3:0] alu_a, alu_b, alu_c;
    logic       alu_ctrl0, alu_ctrl1, alu_ovf;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_c;
    logic       res_ovf;
    logic [7:0] ovf_count;
    logic       busy;
    logic [4:0] alu_sum;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef USE_POWER_PINS
    wire vccd1 = 1'b1;
    wire vssd1 = 1'b0;
`endif

    alu_cmd_sequencer #(.SETTLE_CYCLES(2), .DEPTH(4)) dut (
`ifdef USE_POWER_PINS
        .vccd1     (vccd1),
        .vssd1     (vssd1),
`endif
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl0 (alu_ctrl0),
        .alu_ctrl1 (alu_ctrl1),
        .alu_c     (alu_c),
        .alu_ovf   (alu_ovf),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_c     (res_c),
        .res_ovf   (res_ovf),
        .ovf_count (ovf_count),
        .busy      (busy)
    );

    // Combinational ALU stub: sum with carry-out as overflow.
    assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_c   = alu_sum[3:0];
    assign alu_ovf = alu_sum[4];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one time step after the accepting edge.
    task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        int n = 0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (!cmd_ready) check("push_timeout", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res(input string tag);
        int n = 0;
        while (!res_valid && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(res_valid), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_alu_a"},     32'(alu_a), 32'd0);
        check({tag, "_alu_b"},     32'(alu_b), 32'd0);
        check({tag, "_ctrl"},      32'({alu_ctrl1, alu_ctrl0}), 32'd0);
        check({tag, "_res_c"},     32'(res_c), 32'd0);
        check({tag, "_res_ovf"},   32'(res_ovf), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_ovf_count"}, 32'(ovf_count), 32'd0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_busy"},      32'(busy), 32'd0);
    endtask

    initial begin
        logic [3:0] exp_c [5];
        logic [3:0] hold_a;
        bit         saw_valid;
        bit         done;

        // Reset state
        #1;
        check_reset_outputs("rst0");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single command 2+3, latency of 1+SETTLE_CYCLES edges
        res_ready = 1'b1;
        push(4'd2, 4'd3, OP0);
        check("lat_k0", 32'(res_valid), 32'd0);
        tick();
        check("lat_k1", 32'(res_valid), 32'd0);
        check("lat_alu_a", 32'(alu_a), 32'd2);
        check("lat_busy", 32'(busy), 32'd1);
        tick();
        check("lat_k2", 32'(res_valid), 32'd0);
        tick();
        check("lat_k3", 32'(res_valid), 32'd1);
        check("single_c", 32'(res_c), 32'd5);
        check("single_ovf", 32'(res_ovf), 32'd0);
        check("single_cnt", 32'(ovf_count), 32'd0);
        tick();
        check("single_consumed", 32'(res_valid), 32'd0);
        check("single_idle", 32'(busy), 32'd0);

        // Overflow 7+12, op3 drives both control bits
        push(4'd7, 4'd12, OP3);
        tick();
        check("ovf_ctrl", 32'({alu_ctrl1, alu_ctrl0}), 32'd3);
        wait_res("ovf_wait");
        check("ovf_c", 32'(res_c), 32'd3);
        check("ovf_flag", 32'(res_ovf), 32'd1);
        check("ovf_cnt1", 32'(ovf_count), 32'd1);
        tick();

        // Five back-to-back pushes with results stalled
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(4'(i + 1), 4'(2 * i), 2'(i));
            exp_c[i] = 4'(i + 1 + 2 * i);
        end
        check("full_ready", 32'(cmd_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        cmd_a = 4'hf; cmd_b = 4'hf; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_blocked", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_res("order_wait");
            check($sformatf("order_c%0d", i), 32'(res_c), 32'(exp_c[i]));
            tick();
            check("order_one_per_hs", 32'(res_valid), 32'd0);
        end
        tick();
        check("order_drained", 32'(busy), 32'd0);
        check("order_cnt", 32'(ovf_count), 32'd1);

        // Random res_ready during HOLD
        res_ready = 1'b0;
        push(4'd9, 4'd9, OP1);
        wait_res("hold_wait");
        hold_a = alu_a;
        done = 1'b0;
        for (int i = 0; i < 16 && !done; i++) begin
            res_ready = (i == 15) ? 1'b1 : 1'($urandom_range(0, 1));
            check("hold_c", 32'(res_c), 32'd2);
            check("hold_alu_a", 32'(alu_a), 32'(hold_a));
            tick();
            if (res_ready) begin
                check("hold_consumed", 32'(res_valid), 32'd0);
                done = 1'b1;
            end else begin
                check("hold_valid", 32'(res_valid), 32'd1);
            end
        end
        check("hold_cnt", 32'(ovf_count), 32'd2);

        // Saturation: 300 overflowing commands on top of two prior overflows
        res_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            push(4'd15, 4'd15, OP2);
        end
        for (int n = 0; n < 100 && (busy || res_valid); n++) tick();
        check("sat_idle", 32'(busy), 32'd0);
        check("sat_cnt", 32'(ovf_count), 32'd255);
        check("sat_last_c", 32'(res_c), 32'd14);

        // Reset while in SETTLE with three commands queued
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(4'd1, 4'd1, OP0);
        wait_res("rst_pre_wait");
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();
        check("rst_pre_settle", 32'({busy, res_valid, cmd_ready}), 32'b101);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        tick();
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_valid || busy) saw_valid = 1'b1;
        end
        check("rst_no_result", 32'(saw_valid), 32'd0);
        res_ready = 1'b1;
        push(4'd2, 4'd3, OP0);
        tick();
        tick();
        tick();
        check("rst_after_valid", 32'(res_valid), 32'd1);
        check("rst_after_c", 32'(res_c), 32'd5);
        check("rst_after_cnt", 32'(ovf_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, edges allowed for the downstream combinational ALU to settle (legal range 1..15).
REQ-002 Parameter DEPTH, default 4, command FIFO depth (power of two, 2..16).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 vccd1, vssd1  inout  1 each  power pins; present only when USE_POWER_PINS is defined.
REQ-006 cmd_valid  in  1  upstream command present.
REQ-007 cmd_ready  out  1  FIFO can accept a command.
REQ-008 cmd_a, cmd_b  in  4 each  operands.
REQ-009 cmd_op  in  2  ALU control code.
REQ-010 alu_a, alu_b  out  4 each  registered operands to the ALU.
REQ-011 alu_ctrl0, alu_ctrl1  out  1 each  registered control bits, cmd_op[0] and cmd_op[1].
REQ-012 alu_c  in  4  ALU result; alu_ovf  in  1  ALU overflow.
REQ-013 res_valid  out  1; res_ready  in  1  result handshake.
REQ-014 res_c  out  4; res_ovf  out  1  captured result.
REQ-015 ovf_count  out  8  saturating count of captured overflows.
REQ-016 busy  out  1  high when state is not IDLE or FIFO is non-empty.

Function
REQ-017 Push occurs on an edge where cmd_valid and cmd_ready are both high; cmd_ready = (count < DEPTH), with no combinational dependence on cmd_valid.
REQ-018 FIFO is strictly in-order; no fall-through: a command pushed at edge k is popped no earlier than edge k+1.
REQ-019 Simultaneous push and pop leaves the count unchanged; pointers wrap modulo DEPTH.
REQ-020 FSM states: IDLE, SETTLE, HOLD.
REQ-021 IDLE with FIFO non-empty: pop head, load alu_a/alu_b/alu_ctrl*, load settle counter with SETTLE_CYCLES-1, go to SETTLE.
REQ-022 SETTLE: counter==0 -> sample alu_c/alu_ovf into res_c/res_ovf, set res_valid, go to HOLD; otherwise decrement.
REQ-023 HOLD: res_valid, res_c, and res_ovf are stable until res_ready is high at an edge; that edge clears res_valid and returns to IDLE.
REQ-024 alu_* outputs change only on a pop and otherwise hold the last command.
REQ-025 Latency: with an empty FIFO in IDLE and SETTLE_CYCLES=N, push at edge k -> res_valid high after edge k+1+N.
REQ-026 ovf_count increments by 1 on each capture with alu_ovf=1 and saturates at 255 (no wrap).
REQ-027 res_ready high outside HOLD is ignored.
REQ-028 cmd_valid while the FIFO is full is not accepted; upstream holds the command.

Reset
REQ-029 rst asserted: FIFO is emptied (pointers and count 0), state is IDLE, and settle counter is 0.
REQ-030 rst asserted: alu_a, alu_b, alu_ctrl0, alu_ctrl1, res_c, res_ovf, res_valid, and ovf_count are 0; cmd_ready=1; busy=0.
REQ-031 Reset mid-operation (SETTLE or HOLD) discards the in-flight result and all queued commands; no res_valid pulse follows.

Structure
REQ-032 Package alu_seq_pkg holds the state enum, the ALU control-code constants (OP0..OP3 = 2'd0..2'd3), and the widths (DATA_W=4, OVF_CNT_W=8).
REQ-033 Sub-module alu_cmd_fifo (parameter DEPTH, 10-bit payload {op,a,b}) implements REQ-017..019; the FSM, capture, and counter live in the top.

Verification
REQ-034 Bench ALU stub: C=A+B, OVF=carry-out; design annotated and simulated the same way as the ALU unit.
REQ-035 Single command A=2, B=3, op=0, res_ready held high, pushed at edge k -> res_valid after edge k+3, res_c=5, res_ovf=0, ovf_count=0.
REQ-036 Five back-to-back pushes, res_ready low -> cmd_ready low after the 4th FIFO entry fills (one command in HOLD); results return in push order once res_ready rises.
REQ-037 A=7, B=12 -> res_c=3, res_ovf=1, ovf_count=1; 300 overflowing commands -> ovf_count=255.
REQ-038 rst pulse while in SETTLE with 3 queued commands -> all outputs per REQ-030, no res_valid for 20 cycles, next pushed command completes normally.
REQ-039 res_ready toggled randomly during HOLD -> res_c stable until handshake, exactly one result consumed per handshake, alu_* unchanged during SETTLE and HOLD.
